// File: rtl/types_pkg.sv
// Shared core types for the load/store path, plus the strobe and responder
// state types used by the handshaked data memory.
package types_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int WORD_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] address_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_rsp_state_e;

endpackage

// File: rtl/strb_ram.sv
// Word-organised RAM with per-byte-lane write strobes and a registered read
// port whose output register can be cleared independently of the array.
module strb_ram
  import types_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr,
  input  logic [IDX_W-1:0] idx,
  input  word_t            wdata,
  input  strb_t            strb,
  output word_t            rdata
);

  word_t mem [DEPTH_WORDS];

  // NOTE: the array is deliberately left out of reset so it maps onto plain
  // RAM macros; only the read register below is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (strb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core's handshaked load/store interface: accepts one
// request, waits LATENCY cycles, performs the access and holds the response.
module dmem_responder
  import types_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     req_valid,
  output logic     req_ready,
  input  logic     req_write,
  input  address_t req_addr,
  input  word_t    req_wdata,
  input  strb_t    req_strb,
  output logic     rsp_valid,
  input  logic     rsp_ready,
  output word_t    rsp_rdata,
  output logic     rsp_err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_rsp_state_e   state;
  logic [CNT_W-1:0] cnt;
  logic             write_q;
  logic [IDX_W-1:0] idx_q;
  word_t            wdata_q;
  strb_t            strb_q;
  logic             err_q;

  logic req_err;
  logic accept;
  logic execute;
  logic rsp_done;

  assign req_ready = (state == IDLE);

  // NOTE: combinational decode uses blocking '=' with every output assigned
  // up front, so no path can leave a value held and infer a latch.
  always_comb begin
    req_err  = (req_addr[1:0] != 2'b00) ||
               (req_addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH_WORDS));
    accept   = req_valid && req_ready;
    execute  = (state == WAIT) && (cnt == '0);
    rsp_done = (state == RESP) && rsp_ready;
  end

  // NOTE: all state is updated with non-blocking '<=' so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            write_q <= req_write;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
            strb_q  <= req_strb;
            err_q   <= req_err;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stores and errored accesses zero the read register; loads fill it.
  strb_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .wr_en (execute && write_q && !err_q),
    .rd_en (execute && !write_q && !err_q),
    .clr   ((execute && (write_q || err_q)) || rsp_done),
    .idx   (idx_q),
    .wdata (wdata_q),
    .strb  (strb_q),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 and one at
// LATENCY=3 share stimulus, with sel choosing which one is driven and observed.
module tb_dmem_responder;
  import types_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     sel;
  logic     req_valid, req_write, rsp_ready;
  address_t req_addr;
  word_t    req_wdata;
  strb_t    req_strb;

  logic  req_ready2, rsp_valid2, rsp_err2, req_ready3, rsp_valid3, rsp_err3;
  word_t rsp_rdata2, rsp_rdata3;

  logic  req_ready, rsp_valid, rsp_err;
  word_t rsp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready && !sel),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready && sel),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  assign req_ready = sel ? req_ready3 : req_ready2;
  assign rsp_valid = sel ? rsp_valid3 : rsp_valid2;
  assign rsp_rdata = sel ? rsp_rdata3 : rsp_rdata2;
  assign rsp_err   = sel ? rsp_err3   : rsp_err2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request for one edge; returns at the falling edge after accept.
  task automatic send(input logic wr, input address_t a, input word_t wd, input strb_t s);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_strb  = s;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_ack_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_ack_rdata", rsp_rdata, 32'd0);
    check("post_ack_err", {31'b0, rsp_err}, 32'd0);
    check("post_ack_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_req(input string tag, input logic wr, input address_t a, input word_t wd,
                        input strb_t s, input int exp_lat, input word_t exp_rd,
                        input logic exp_err);
    int lat;
    send(wr, a, wd, s);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    ack();
  endtask

  initial begin
    int   lat;
    logic seen_valid, seen_not_ready;

    reset = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // LATENCY=2 instance
    do_req("st_full",  1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0);
    do_req("ld_full",  1'b0, 32'h10,  32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0);
    do_req("st_lane0", 1'b1, 32'h10,  32'h000000AA, 4'h1, 2, 32'h0, 1'b0);
    do_req("ld_lane0", 1'b0, 32'h10,  32'h0,        4'h0, 2, 32'hDEADBEAA, 1'b0);
    do_req("st_nostrb",1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 2, 32'h0, 1'b0);
    do_req("ld_nostrb",1'b0, 32'h10,  32'h0,        4'h0, 2, 32'hDEADBEAA, 1'b0);
    do_req("st_lane12",1'b1, 32'h14,  32'h11223344, 4'hF, 2, 32'h0, 1'b0);
    do_req("st_mid",   1'b1, 32'h14,  32'hAABBCCDD, 4'h6, 2, 32'h0, 1'b0);
    do_req("ld_mid",   1'b0, 32'h14,  32'h0,        4'h0, 2, 32'h11BBCC44, 1'b0);
    do_req("ld_misal", 1'b0, 32'h12,  32'h0,        4'h0, 2, 32'h0, 1'b1);
    do_req("st_misal", 1'b1, 32'h11,  32'h55555555, 4'hF, 2, 32'h0, 1'b1);
    do_req("ld_after_misal", 1'b0, 32'h10, 32'h0,   4'h0, 2, 32'hDEADBEAA, 1'b0);
    do_req("st_w0",    1'b1, 32'h0,   32'h0BADF00D, 4'hF, 2, 32'h0, 1'b0);
    do_req("st_oor",   1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 2, 32'h0, 1'b1);
    do_req("ld_w0",    1'b0, 32'h0,   32'h0,        4'h0, 2, 32'h0BADF00D, 1'b0);
    do_req("st_last",  1'b1, 32'h3FC, 32'h5A5AA5A5, 4'hF, 2, 32'h0, 1'b0);
    do_req("ld_last",  1'b0, 32'h3FC, 32'h0,        4'h0, 2, 32'h5A5AA5A5, 1'b0);

    // Backpressure: hold the load response five cycles and poke a store at it
    send(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    check("bp_lat", lat, 2);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
        req_wdata = 32'h12345678; req_strb = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEADBEAA);
      check("bp_err", {31'b0, rsp_err}, 32'd0);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    ack();
    do_req("ld_after_bp", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEAA, 1'b0);

    // LATENCY=3 instance: reset one cycle after a store is accepted
    sel = 1'b1;
    do_req("l3_st_pre", 1'b1, 32'h20, 32'h11223344, 4'hF, 3, 32'h0, 1'b0);
    send(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    check("l3_wait_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("l3_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("l3_rst_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen_valid = 1'b0;
    seen_not_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1'b1;
      if (!req_ready) seen_not_ready = 1'b1;
    end
    check("l3_no_rsp_after_rst", {31'b0, seen_valid}, 32'd0);
    check("l3_ready_after_rst", {31'b0, seen_not_ready}, 32'd0);
    do_req("l3_ld_pre", 1'b0, 32'h20, 32'h0, 4'h0, 3, 32'h11223344, 1'b0);

    // Reset while in RESP keeps the already-executed store
    send(1'b1, 32'h24, 32'h89ABCDEF, 4'hF);
    wait_rsp(lat);
    check("l3_resp_lat", lat, 3);
    reset = 1'b1;
    #1;
    check("l3_resp_rst_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_req("l3_ld_kept", 1'b0, 32'h24, 32'h0, 4'h0, 3, 32'h89ABCDEF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
